// File: rtl/ysyx_24110006_icache_sa_if.sv
// ysyx_24110006_icache_sa_if
// Bundles the fetch-side handshake (IFU) and the AXI4 read channels
// (memory arbiter) of the set-associative instruction cache.
// Signal names keep the cache's point of view: i_* flows into the cache,
// o_* flows out of it.
//   slave  : the cache itself
//   master : the environment (IFU + AXI read slave)
interface ysyx_24110006_icache_sa_if;
  // fetch side
  logic [31:0] i_pc;
  logic        i_valid;
  logic        i_fence;
  logic        o_valid;
  logic [31:0] o_inst;
  logic        o_err;
  logic        o_hit;
  logic        o_miss;
  // AXI4 read address channel
  logic [31:0] o_axi_araddr;
  logic        o_axi_arvalid;
  logic [3:0]  o_axi_arid;
  logic [7:0]  o_axi_arlen;
  logic [2:0]  o_axi_arsize;
  logic [1:0]  o_axi_arburst;
  logic        i_axi_arready;
  // AXI4 read data channel
  logic [31:0] i_axi_rdata;
  logic        i_axi_rvalid;
  logic [1:0]  i_axi_rresp;
  logic [3:0]  i_axi_rid;
  logic        i_axi_rlast;
  logic        o_axi_rready;

  modport slave (
    input  i_pc, i_valid, i_fence,
    output o_valid, o_inst, o_err, o_hit, o_miss,
    output o_axi_araddr, o_axi_arvalid, o_axi_arid, o_axi_arlen, o_axi_arsize, o_axi_arburst,
    input  i_axi_arready,
    input  i_axi_rdata, i_axi_rvalid, i_axi_rresp, i_axi_rid, i_axi_rlast,
    output o_axi_rready
  );

  modport master (
    output i_pc, i_valid, i_fence,
    input  o_valid, o_inst, o_err, o_hit, o_miss,
    input  o_axi_araddr, o_axi_arvalid, o_axi_arid, o_axi_arlen, o_axi_arsize, o_axi_arburst,
    output i_axi_arready,
    output i_axi_rdata, i_axi_rvalid, i_axi_rresp, i_axi_rid, i_axi_rlast,
    input  o_axi_rready
  );
endinterface

// File: rtl/ysyx_24110006_icache_sa.sv
// ysyx_24110006_icache_sa
// Parametrised set-associative instruction cache between the IFU and the
// AXI4 read port of the memory arbiter. Misses refill a whole line with an
// INCR burst; addresses whose top byte equals UNCACHED_TOP bypass the arrays
// as single-beat reads. Supports a global invalidate (fence.i), AXI error
// reporting and hit/miss pulses for performance counters.
// Ports:
//   i_clock : clock
//   i_reset : synchronous active-high reset
//   bus     : fetch handshake + AXI4 read channels (slave modport)
module ysyx_24110006_icache_sa #(
  parameter int          NUM_SETS     = 4,
  parameter int          NUM_WAYS     = 2,
  parameter int          BLOCK_SIZE   = 16,
  parameter logic [7:0]  UNCACHED_TOP = 8'h0f
) (
  input logic                      i_clock,
  input logic                      i_reset,
  ysyx_24110006_icache_sa_if.slave bus
);

  localparam int OFFSET = $clog2(BLOCK_SIZE);
  localparam int INDEX  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - INDEX - OFFSET;
  localparam int WORDS  = BLOCK_SIZE / 4;
  localparam int IDX_W  = (INDEX > 0) ? INDEX : 1;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WRD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_UNC} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               fence_pending_q, fence_pending_d;
  logic               arvalid_q, arvalid_d;
  logic               o_valid_q, o_valid_d;
  logic               o_err_q, o_err_d;
  logic [31:0]        o_inst_q, o_inst_d;
  logic [WRD_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               err_acc_q, err_acc_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic               victim_rr_q, victim_rr_d;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [WAY_W-1:0]   rr_q [NUM_SETS];
  logic [WAY_W-1:0]   rr_d [NUM_SETS];

  // storage arrays; no reset, qualified by the valid bits
  logic [TAG_W-1:0]   tag_q  [NUM_SETS][NUM_WAYS];
  logic [31:0]        data_q [NUM_SETS][NUM_WAYS][WORDS];

  logic [IDX_W-1:0]   set_idx;
  logic [WRD_W-1:0]   word_idx;
  logic [TAG_W-1:0]   tag_in;
  logic               hit;
  logic [31:0]        hit_data;
  logic               inv_found;
  logic [WAY_W-1:0]   inv_way;
  logic [WAY_W-1:0]   rr_inc;
  logic               beat_err;
  logic               fill_we;
  logic               tag_we;
  logic               unused_ok;

  // address split of the latched request
  assign set_idx  = IDX_W'((pc_q >> OFFSET) & 32'(NUM_SETS - 1));
  assign word_idx = WRD_W'((pc_q >> 2) & 32'(WORDS - 1));
  assign tag_in   = TAG_W'(pc_q >> (OFFSET + INDEX));
  assign rr_inc   = WAY_W'((32'(rr_q[set_idx]) + 32'd1) % NUM_WAYS);
  assign beat_err = (bus.i_axi_rresp != 2'b00);

  // tag compare across all ways of the selected set
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
        hit      = 1'b1;
        hit_data = data_q[set_idx][w][word_idx];
      end
    end
  end

  // lowest-index invalid way; scanning downward lets the lowest win
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    fence_pending_d = fence_pending_q | bus.i_fence;
    arvalid_d       = arvalid_q & ~bus.i_axi_arready;
    o_valid_d       = 1'b0;
    o_err_d         = o_err_q;
    o_inst_d        = o_inst_q;
    beat_cnt_d      = beat_cnt_q;
    err_acc_d       = err_acc_q;
    victim_d        = victim_q;
    victim_rr_d     = victim_rr_q;
    valid_d         = valid_q;
    rr_d            = rr_q;
    fill_we         = 1'b0;
    tag_we          = 1'b0;

    case (state_q)
      S_IDLE: begin
        // a fence (pending or arriving now) wins over a request; the
        // requester keeps i_valid up, so it is taken the next cycle
        if (fence_pending_q || bus.i_fence) begin
          for (int s = 0; s < NUM_SETS; s++) valid_d[s] = '0;
          fence_pending_d = 1'b0;
        end else if (bus.i_valid && !o_valid_q) begin
          pc_d = bus.i_pc;
          if (bus.i_pc[31:24] == UNCACHED_TOP) begin
            state_d   = S_UNC;
            arvalid_d = 1'b1;
          end else begin
            state_d = S_LOOKUP;
          end
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          o_inst_d  = hit_data;
          o_err_d   = 1'b0;
          o_valid_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          victim_d    = inv_found ? inv_way : rr_q[set_idx];
          victim_rr_d = ~inv_found;
          // the victim is overwritten beat by beat, so it must not stay
          // valid under its old tag if the refill ends in error
          if (inv_found) valid_d[set_idx][inv_way] = 1'b0;
          else           valid_d[set_idx][rr_q[set_idx]] = 1'b0;
          beat_cnt_d  = '0;
          err_acc_d   = 1'b0;
          arvalid_d   = 1'b1;
          state_d     = S_REFILL;
        end
      end

      S_REFILL: begin
        if (bus.i_axi_rvalid) begin
          fill_we    = 1'b1;
          beat_cnt_d = beat_cnt_q + WRD_W'(1);
          err_acc_d  = err_acc_q | beat_err;
          if (beat_cnt_q == word_idx) o_inst_d = bus.i_axi_rdata;
          if (bus.i_axi_rlast) begin
            beat_cnt_d = '0;
            err_acc_d  = 1'b0;
            if (!(err_acc_q | beat_err)) begin
              valid_d[set_idx][victim_q] = 1'b1;
              tag_we = 1'b1;
              if (victim_rr_q) rr_d[set_idx] = rr_inc;
            end
            o_err_d   = err_acc_q | beat_err;
            o_valid_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

      S_UNC: begin
        if (bus.i_axi_rvalid) begin
          o_inst_d  = bus.i_axi_rdata;
          o_err_d   = beat_err;
          o_valid_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // control state with synchronous reset; a reset mid-refill simply drops
  // the line because all valid bits clear
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q         <= S_IDLE;
      pc_q            <= '0;
      fence_pending_q <= 1'b0;
      arvalid_q       <= 1'b0;
      o_valid_q       <= 1'b0;
      o_err_q         <= 1'b0;
      o_inst_q        <= '0;
      beat_cnt_q      <= '0;
      err_acc_q       <= 1'b0;
      victim_q        <= '0;
      victim_rr_q     <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      fence_pending_q <= fence_pending_d;
      arvalid_q       <= arvalid_d;
      o_valid_q       <= o_valid_d;
      o_err_q         <= o_err_d;
      o_inst_q        <= o_inst_d;
      beat_cnt_q      <= beat_cnt_d;
      err_acc_q       <= err_acc_d;
      victim_q        <= victim_d;
      victim_rr_q     <= victim_rr_d;
      valid_q         <= valid_d;
      rr_q            <= rr_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset && fill_we) data_q[set_idx][victim_q][beat_cnt_q] <= bus.i_axi_rdata;
    if (!i_reset && tag_we)  tag_q[set_idx][victim_q] <= tag_in;
  end

  assign bus.o_valid       = o_valid_q;
  assign bus.o_inst        = o_inst_q;
  assign bus.o_err         = o_err_q;
  assign bus.o_hit         = (state_q == S_LOOKUP) &  hit;
  assign bus.o_miss        = (state_q == S_LOOKUP) & ~hit;

  // address/length derive from the latched pc and state, so they hold
  // steady for as long as arvalid is up
  assign bus.o_axi_arvalid = arvalid_q;
  assign bus.o_axi_araddr  = (state_q == S_UNC) ? pc_q : (pc_q & ~32'(BLOCK_SIZE - 1));
  assign bus.o_axi_arlen   = (state_q == S_UNC) ? 8'd0 : 8'(WORDS - 1);
  assign bus.o_axi_arburst = (state_q == S_UNC) ? 2'b00 : 2'b01;
  assign bus.o_axi_arsize  = 3'b010;
  assign bus.o_axi_arid    = 4'd0;
  assign bus.o_axi_rready  = 1'b1;

  // response id is not needed: only one read is ever outstanding
  assign unused_ok = ^bus.i_axi_rid;

endmodule
